// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two-master Wishbone arbiter in front of the on-chip word RAM.
// Master 0 is instruction fetch, master 1 is the load/store unit. Requests are
// serialised into single-beat slave transactions with a one-cycle s_cyc_o strobe.
// Read data, ack, or a timeout error go back to the granted master only.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   mN_adr/dat/sel/we/cyc_i     master N request (N = 0, 1); cyc held until ack/err
//   mN_ack_o, mN_err_o          one-cycle completion / timeout pulses
//   mN_dat_o                    read data, valid with mN_ack_o, zero otherwise
//   s_adr/dat/sel/we/cyc_o      slave request
//   s_ack_i, s_dat_i            slave response
module wb_ram_arbiter #(
  parameter int dw      = 32,
  parameter int aw      = 10,
  parameter int timeout = 15
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [aw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [dw-1:0] m0_dat_o,
  input  logic [aw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [dw-1:0] m1_dat_o,
  output logic [aw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  input  logic          s_ack_i,
  input  logic [dw-1:0] s_dat_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(timeout - 1);

  state_t     state_q;
  logic       grant_q;       // 0 = master 0, 1 = master 1
  logic       last_grant_q;
  logic       abort_q;       // granted master dropped cyc mid-transaction
  logic       s_cyc_q;
  logic [7:0] cnt_q;

  logic [1:0] req;
  logic       grant_pick;
  logic       g_cyc;
  logic       live;
  logic       fire_ack;
  logic       fire_err;
  logic [1:0] m_ack;
  logic [1:0] m_err;
  logic [dw-1:0] m_dat [2];

  assign req = {m1_cyc_i, m0_cyc_i};
  // Contested requests go to the master that was not served last.
  assign grant_pick = (req == 2'b11) ? ~last_grant_q : req[1];
  assign g_cyc = grant_q ? m1_cyc_i : m0_cyc_i;
  // Responses are only forwarded while the granted master is still asking.
  assign live = ~abort_q & g_cyc;
  assign fire_ack = (state_q == WAIT) & s_ack_i;
  assign fire_err = (state_q == WAIT) & ~s_ack_i & (cnt_q == TMO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      abort_q      <= 1'b0;
      s_cyc_q      <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          cnt_q   <= 8'd0;
          s_cyc_q <= 1'b0;
          if (|req) begin
            grant_q      <= grant_pick;
            last_grant_q <= grant_pick;
            s_cyc_q      <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          s_cyc_q <= 1'b0;
          cnt_q   <= 8'd0;
          if (!g_cyc) abort_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (!g_cyc) abort_q <= 1'b1;
          if (fire_ack || fire_err) state_q <= DONE;
          else cnt_q <= cnt_q + 8'd1;
        end
        DONE: begin
          // Dead cycle: lets the master drop cyc before re-arbitration.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Address and selects stay on the granted master through WAIT because the
  // RAM read port is registered; write enable only qualifies the strobe cycle.
  assign s_adr_o = grant_q ? m1_adr_i : m0_adr_i;
  assign s_dat_o = grant_q ? m1_dat_i : m0_dat_i;
  assign s_sel_o = grant_q ? m1_sel_i : m0_sel_i;
  assign s_we_o  = s_cyc_q & (grant_q ? m1_we_i : m0_we_i);
  assign s_cyc_o = s_cyc_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_master_resp
    assign m_ack[gi] = fire_ack & live & (grant_q == 1'(gi));
    assign m_err[gi] = fire_err & live & (grant_q == 1'(gi));
    assign m_dat[gi] = m_ack[gi] ? s_dat_i : '0;
  end

  assign m0_ack_o = m_ack[0];
  assign m0_err_o = m_err[0];
  assign m0_dat_o = m_dat[0];
  assign m1_ack_o = m_ack[1];
  assign m1_err_o = m_err[1];
  assign m1_dat_o = m_dat[1];

endmodule
